// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the N-requester bus arbiter.
// State encodings plus width helpers used by the top and picker.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_GRANT = 2'b01,
        ARB_TURN  = 2'b10
    } arb_state_e;

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_w(input int m);
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/bus_arb_n_rr_pick.sv
// Combinational rotating-priority picker for the bus arbiter.
// Masked requesters lose only while an unmasked competitor exists.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    input  logic [W-1:0] ptr,
    input  logic         mode,
    output logic         hit,
    output logic [W-1:0] idx
);

    logic [N-1:0] eff;
    logic         found;
    int           start;
    int           j;

    // Scan from the start point, wrapping, and take the first eligible bit.
    always_comb begin
        eff = req & ~mask;
        if (eff == '0) begin
            eff = req;
        end
        start = 0;
        if (mode && (int'(ptr) < N)) begin
            start = int'(ptr);
        end
        hit   = |req;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = start + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && eff[W'(j)]) begin
                found = 1'b1;
                idx   = W'(j);
            end
        end
    end

endmodule

// File: rtl/bus_arb_n.sv
// N-requester shared-bus arbiter with turnaround and tenure limit.
// Registered grant/grant_id drive the bus mux select directly.
module bus_arb_n
    import bus_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_REQ-1:0]          breq,
    input  logic                      rr_mode,
    output logic [N_REQ-1:0]          grant,
    output logic [idx_w(N_REQ)-1:0]   grant_id,
    output logic                      bus_busy,
    output logic                      preempt
);

    localparam int IW = idx_w(N_REQ);
    localparam int HW = cnt_w(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST =
        HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [IW-1:0] ID_LAST = IW'(N_REQ - 1);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic [N_REQ-1:0]  grant_d;
    logic [IW-1:0]     id_d;
    logic              busy_d;
    logic              preempt_d;
    logic [HW-1:0]     hold_q;
    logic [HW-1:0]     hold_d;
    logic [IW-1:0]     ptr_q;
    logic [IW-1:0]     ptr_d;
    logic [N_REQ-1:0]  mask_q;
    logic [N_REQ-1:0]  mask_d;

    logic              pick_hit;
    logic [IW-1:0]     pick_idx;
    logic [IW-1:0]     ptr_nxt;
    logic [N_REQ-1:0]  grant_sel;
    logic              owner_req;
    logic              others_req;
    logic              at_limit;

    rr_pick #(
        .N (N_REQ),
        .W (IW)
    ) u_pick (
        .req  (breq),
        .mask (mask_q),
        .ptr  (ptr_q),
        .mode (rr_mode),
        .hit  (pick_hit),
        .idx  (pick_idx)
    );

    assign ptr_nxt    = (pick_idx == ID_LAST) ? '0 : pick_idx + 1'b1;
    assign owner_req  = breq[grant_id];
    assign others_req = |(breq & ~grant);
    assign at_limit   = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

    // One-hot decode of the picker's winner.
    always_comb begin
        grant_sel           = '0;
        grant_sel[pick_idx] = 1'b1;
    end

    // Next state and next registered outputs; every ownership change
    // passes through TURN so the bus always sees a dead cycle.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant;
        id_d      = grant_id;
        preempt_d = 1'b0;
        hold_d    = hold_q;
        ptr_d     = ptr_q;
        mask_d    = mask_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_hit) begin
                    state_d = ARB_GRANT;
                    grant_d = grant_sel;
                    id_d    = pick_idx;
                    hold_d  = '0;
                    ptr_d   = ptr_nxt;
                end
            end
            ARB_GRANT: begin
                if (!owner_req) begin
                    state_d = ARB_TURN;
                    grant_d = '0;
                end else if (at_limit && others_req) begin
                    state_d   = ARB_TURN;
                    grant_d   = '0;
                    preempt_d = 1'b1;
                    mask_d    = grant;
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ARB_TURN: begin
                mask_d = '0;
                if (pick_hit) begin
                    state_d = ARB_GRANT;
                    grant_d = grant_sel;
                    id_d    = pick_idx;
                    hold_d  = '0;
                    ptr_d   = ptr_nxt;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
                mask_d  = '0;
                hold_d  = '0;
            end
        endcase
        busy_d = |grant_d;
    end

    // State, bookkeeping and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ARB_IDLE;
            grant    <= '0;
            grant_id <= '0;
            bus_busy <= 1'b0;
            preempt  <= 1'b0;
            hold_q   <= '0;
            ptr_q    <= '0;
            mask_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant    <= grant_d;
            grant_id <= id_d;
            bus_busy <= busy_d;
            preempt  <= preempt_d;
            hold_q   <= hold_d;
            ptr_q    <= ptr_d;
            mask_q   <= mask_d;
        end
    end

endmodule

// File: tb/tb_bus_arb_n.sv
// Bench for bus_arb_n: two instances (no limit / limit 8) share stimulus
// and are compared every cycle against an ownership-level model.
module tb_bus_arb_n;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] breq;
    logic       rr_mode;

    logic [3:0] g0, g8;
    logic [1:0] id0, id8;
    logic       busy0, busy8;
    logic       pre0, pre8;

    int checks = 0;
    int errors = 0;

    // model: phase 0 idle, 1 owned, 2 dead cycle
    int M_HOLD [2] = '{0, 8};
    int m_ph   [2];
    int m_own  [2];
    int m_ten  [2];
    int m_ptr  [2];
    int m_excl [2];
    int m_id   [2];
    bit m_pre  [2];

    logic [3:0] hist_g [32];
    bit         hist_p [32];
    int         seq    [$];

    always #5 clk = ~clk;

    bus_arb_n #(.N_REQ(4), .MAX_HOLD(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .breq(breq), .rr_mode(rr_mode),
        .grant(g0), .grant_id(id0), .bus_busy(busy0), .preempt(pre0)
    );

    bus_arb_n #(.N_REQ(4), .MAX_HOLD(8)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .breq(breq), .rr_mode(rr_mode),
        .grant(g8), .grant_id(id8), .bus_busy(busy8), .preempt(pre8)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] bitof(input int i);
        logic [3:0] v;
        v = 4'b0001 << i;
        return v;
    endfunction

    function automatic int pick(input int k, input logic [3:0] req,
                                input bit rr);
        logic [3:0] c;
        int start;
        int j;
        c = req;
        if (m_excl[k] >= 0 && (req & ~bitof(m_excl[k])) != 4'b0)
            c = req & ~bitof(m_excl[k]);
        start = rr ? m_ptr[k] : 0;
        for (int i = 0; i < 4; i++) begin
            j = (start + i) % 4;
            if (c[2'(j)]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ph[k] = 0; m_own[k] = 0; m_ten[k] = 0; m_ptr[k] = 0;
            m_excl[k] = -1; m_id[k] = 0; m_pre[k] = 0;
        end
    endtask

    task automatic give(input int k, input int w);
        m_own[k] = w; m_id[k] = w; m_ph[k] = 1; m_ten[k] = 1;
        m_ptr[k] = (w + 1) % 4;
    endtask

    task automatic model_edge(input logic [3:0] req, input bit rr);
        int w;
        for (int k = 0; k < 2; k++) begin
            m_pre[k] = 0;
            case (m_ph[k])
                0: begin
                    w = pick(k, req, rr);
                    if (w >= 0) give(k, w);
                end
                1: begin
                    if (!req[2'(m_own[k])]) begin
                        m_ph[k] = 2;
                    end else if (M_HOLD[k] > 0 && m_ten[k] >= M_HOLD[k] &&
                                 (req & ~bitof(m_own[k])) != 4'b0) begin
                        m_ph[k] = 2; m_pre[k] = 1; m_excl[k] = m_own[k];
                    end else begin
                        m_ten[k]++;
                    end
                end
                default: begin
                    w = pick(k, req, rr);
                    m_excl[k] = -1;
                    if (w >= 0) give(k, w);
                    else m_ph[k] = 0;
                end
            endcase
        end
    endtask

    task automatic check_all();
        logic [3:0] eg;
        for (int k = 0; k < 2; k++) begin
            eg = (m_ph[k] == 1) ? bitof(m_own[k]) : 4'b0;
            chk($sformatf("grant%0d", M_HOLD[k]), k ? g8 : g0, eg);
            chk($sformatf("id%0d", M_HOLD[k]), k ? id8 : id0, m_id[k]);
            chk($sformatf("busy%0d", M_HOLD[k]), k ? busy8 : busy0,
                m_ph[k] == 1);
            chk($sformatf("preempt%0d", M_HOLD[k]), k ? pre8 : pre0,
                m_pre[k]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(breq, rr_mode);
        #1;
        check_all();
    endtask

    task automatic drain();
        breq = 4'b0;
        repeat (3) step();
    endtask

    initial begin
        reset_n = 1'b0;
        breq    = 4'b0;
        rr_mode = 1'b0;
        model_reset();
        #12;
        chk("rst_grant", {g8, g0}, 8'h00);
        chk("rst_misc", {id8, id0, busy8, busy0, pre8, pre0}, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;

        // fixed priority, 1010 then drop requester 1
        breq = 4'b1010;
        step();
        chk("fp_first", g0, 4'b0010);
        breq = 4'b1000;
        step();
        chk("fp_dead", g0, 4'b0000);
        step();
        chk("fp_next", g0, 4'b1000);
        drain();

        // round robin, each owner drops for one cycle after its grant
        rr_mode = 1'b1;
        breq = 4'hF;
        for (int c = 0; c < 10; c++) begin
            step();
            if (g0 != 4'b0) seq.push_back(int'(id0));
            breq = (g0 != 4'b0) ? (4'hF & ~g0) : 4'hF;
        end
        chk("rr_len", seq.size(), 5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("rr_seq%0d", i),
                (i < seq.size()) ? seq[i] : -1, i % 4);
        drain();

        // tenure limit: requester 2 arrives at cycle 3
        rr_mode = 1'b0;
        breq = 4'b0001;
        for (int c = 0; c < 12; c++) begin
            step();
            hist_g[c] = g8;
            hist_p[c] = pre8;
            if (c == 2) breq = 4'b0101;
        end
        chk("pre_last", hist_g[7], 4'b0001);
        chk("pre_dead", hist_g[8], 4'b0000);
        chk("pre_pulse", hist_p[8], 1'b1);
        chk("pre_next", hist_g[9], 4'b0100);
        drain();

        // sole requester is never preempted
        begin
            int n_own = 0;
            int n_pre = 0;
            breq = 4'b0001;
            for (int c = 0; c < 20; c++) begin
                step();
                if (g8 == 4'b0001) n_own++;
                if (pre8) n_pre++;
            end
            chk("solo_own", n_own, 20);
            chk("solo_pre", n_pre, 0);
        end
        drain();

        // release coincides with the limit: release wins
        breq = 4'b1010;
        for (int c = 0; c < 12; c++) begin
            step();
            hist_g[c] = g8;
            hist_p[c] = pre8;
            if (c == 7) breq = 4'b1000;
        end
        chk("rel_dead", hist_g[8], 4'b0000);
        chk("rel_nopre", hist_p[8], 1'b0);
        chk("rel_next", hist_g[9], 4'b1000);
        drain();

        // asynchronous reset mid-tenure
        breq = 4'b0100;
        step();
        chk("ar_pre", g8, 4'b0100);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("ar_grant", {g8, g0}, 8'h00);
        chk("ar_misc", {id8, id0, busy8, busy0, pre8, pre0}, 8'h00);
        breq = 4'b0001;
        #1;
        reset_n = 1'b1;
        step();
        chk("ar_after", g8, 4'b0001);

        // randomized traffic
        for (int c = 0; c < 800; c++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(5) == 0) breq[b] = ~breq[b];
            if ($urandom_range(19) == 0) rr_mode = ~rr_mode;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
